// File: rtl/itch_pkg.sv
// itch_pkg: shared ITCH sizes, assembler FSM states and message-type bytes
package itch_pkg;
  localparam int MAX_BYTES_DEF = 64;
  localparam int PAYLOAD_W = MAX_BYTES_DEF * 8;
  localparam int LEN_W = 16;
  typedef enum logic [1:0] {LEN_HI, LEN_LO, BODY, DROP} state_t;
  localparam logic [7:0] MSG_SYSTEM = 8'h53;
  localparam logic [7:0] MSG_ADD = 8'h41;
  localparam logic [7:0] MSG_ADD_MPID = 8'h46;
  localparam logic [7:0] MSG_EXEC = 8'h45;
  localparam logic [7:0] MSG_EXEC_PRICE = 8'h43;
  localparam logic [7:0] MSG_CANCEL = 8'h58;
  localparam logic [7:0] MSG_DELETE = 8'h44;
  localparam logic [7:0] MSG_REPLACE = 8'h55;
  localparam logic [7:0] MSG_TRADE = 8'h50;
endpackage

// File: rtl/itch_sat_counter.sv
// itch_sat_counter: event counter that either wraps or holds at all-ones
module itch_sat_counter #(
  parameter int W = 16,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  // count one per inc; when saturating, an all-ones value is held
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && !(SAT && &count)) count <= count + W'(1);
endmodule

// File: rtl/itch_payload_assembler.sv
// itch_payload_assembler: packs length-prefixed ITCH messages into left-aligned payloads
module itch_payload_assembler
  import itch_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEF,
  parameter int CNT_W = 32,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_byte,
  input  logic                   in_flush,
  output logic                   payload_valid,
  output logic [MAX_BYTES*8-1:0] payload,
  output logic [LEN_W-1:0]       payload_len,
  output logic                   drop_pulse,
  output logic [CNT_W-1:0]       msg_count,
  output logic [DROP_W-1:0]      drop_count
);
  localparam int PW = MAX_BYTES * 8;
  state_t state;
  logic [LEN_W-1:0] len, idx, len_next;
  logic [PW-1:0] asm_buf;
  logic done, last, drop_ev;
  // full length as it completes, end of a body/drop run, and malformed-length detection
  always_comb begin
    len_next = {len[15:8], in_byte};
    last = idx == len - LEN_W'(1);
    drop_ev = in_valid && !in_flush && state == LEN_LO &&
              (len_next == '0 || len_next > LEN_W'(MAX_BYTES));
  end
  // framing FSM; done delays publication one edge so payload copies the finished buffer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LEN_HI;
      len <= '0;
      idx <= '0;
      asm_buf <= '0;
      done <= 1'b0;
      payload_valid <= 1'b0;
      payload <= '0;
      payload_len <= '0;
      drop_pulse <= 1'b0;
    end else begin
      done <= 1'b0;
      payload_valid <= done;
      drop_pulse <= drop_ev;
      if (done) begin
        payload <= asm_buf;
        payload_len <= len;
      end
      if (in_flush) begin
        state <= LEN_HI;
        idx <= '0;
      end else if (in_valid) begin
        case (state)
          LEN_HI: begin
            len[15:8] <= in_byte;
            state <= LEN_LO;
          end
          LEN_LO: begin
            len[7:0] <= in_byte;
            idx <= '0;
            state <= drop_ev ? (len_next == '0 ? LEN_HI : DROP) : BODY;
            if (!drop_ev) asm_buf <= '0;
          end
          BODY: begin
            for (int j = 0; j < MAX_BYTES; j++)
              if (idx == LEN_W'(j)) asm_buf[PW-1-8*j -: 8] <= in_byte;
            idx <= idx + LEN_W'(1);
            if (last) begin
              done <= 1'b1;
              state <= LEN_HI;
            end
          end
          default: begin
            idx <= idx + LEN_W'(1);
            if (last) state <= LEN_HI;
          end
        endcase
      end
    end
  itch_sat_counter #(.W(CNT_W), .SAT(1'b0)) u_msg_cnt (
    .clk(clk), .rst_n(rst_n), .inc(done), .count(msg_count)
  );
  itch_sat_counter #(.W(DROP_W), .SAT(1'b1)) u_drop_cnt (
    .clk(clk), .rst_n(rst_n), .inc(drop_ev), .count(drop_count)
  );
endmodule

// File: tb/tb_itch_payload_assembler.sv
// tb_itch_payload_assembler: vectors, corner sequences and random streams against a parse model
module tb_itch_payload_assembler;
  logic clk = 0, rst_n = 0, in_valid = 0, in_flush = 0;
  logic [7:0] in_byte = 0;
  logic payload_valid, drop_pulse;
  logic [511:0] payload;
  logic [15:0] payload_len;
  logic [3:0] msg_count;
  logic [2:0] drop_count;
  int n_pass = 0, n_tot = 0, cyc = 0, overlap = 0;
  logic [511:0] obs_pl[$], exp_pl[$];
  int obs_len[$], exp_len[$], pcyc[$];
  typedef struct {
    int n;
    logic [127:0] s;
    int len;
    logic [127:0] top;
  } vec_t;
  vec_t vt[5];

  itch_payload_assembler #(.MAX_BYTES(64), .CNT_W(4), .DROP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte), .in_flush(in_flush),
    .payload_valid(payload_valid), .payload(payload), .payload_len(payload_len),
    .drop_pulse(drop_pulse), .msg_count(msg_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (payload_valid) begin
      obs_pl.push_back(payload);
      obs_len.push_back(int'(payload_len));
      pcyc.push_back(cyc);
    end
    if (payload_valid && drop_pulse) overlap++;
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1;
    in_byte = b;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_q(input logic [7:0] s[$], input int maxgap);
    foreach (s[k]) send(s[k], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_run(input logic [7:0] s[$], output int drops);
    int i, l;
    logic [511:0] p;
    i = 0;
    drops = 0;
    while (i + 1 < s.size()) begin
      l = int'({s[i], s[i+1]});
      i += 2;
      if (l == 0) drops++;
      else if (l > 64) begin
        drops++;
        i += l;
      end else begin
        p = '0;
        for (int k = 0; k < l; k++) p[511-8*k -: 8] = s[i+k];
        exp_pl.push_back(p);
        exp_len.push_back(l);
        i += l;
      end
    end
  endtask

  initial begin
    logic [7:0] s1[$], s2[$], sr[$];
    int n0, drops, tot_msgs;
    vt[0] = '{15, 128'h000D5801020304050607080000006400, 13, 128'h58010203040506070800000064000000};
    vt[1] = '{5, 128'h00034142430000000000000000000000, 3, 128'h41424300000000000000000000000000};
    vt[2] = '{3, 128'h00015800000000000000000000000000, 1, 128'h58000000000000000000000000000000};
    vt[3] = '{4, 128'h00024445000000000000000000000000, 2, 128'h44450000000000000000000000000000};
    vt[4] = '{16, 128'h000EA1A2A3A4A5A6A7A8A9AAABACADAE, 14, 128'hA1A2A3A4A5A6A7A8A9AAABACADAE0000};
    repeat (3) tick();
    chk("rst_valid", 512'(payload_valid), 512'(0));
    chk("rst_payload", payload, 512'(0));
    chk("rst_len", 512'(payload_len), 512'(0));
    chk("rst_drop", 512'(drop_pulse), 512'(0));
    chk("rst_msgcnt", 512'(msg_count), 512'(0));
    chk("rst_dropcnt", 512'(drop_count), 512'(0));
    rst_n = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < vt[i].n; k++) send(vt[i].s[127-8*k -: 8], 0);
      chk("vec_early", 512'(payload_valid), 512'(0));
      tick();
      chk("vec_valid", 512'(payload_valid), 512'(1));
      chk("vec_payload", payload, {vt[i].top, 384'b0});
      chk("vec_len", 512'(payload_len), 512'(vt[i].len));
      chk("vec_msgcnt", 512'(msg_count), 512'(i + 1));
      tick();
      chk("vec_pulse_end", 512'(payload_valid), 512'(0));
    end
    s1 = '{8'h00, 8'h0D, 8'h58, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
           8'h00, 8'h00, 8'h00, 8'h64};
    s2 = '{8'h00, 8'h0D};
    for (int k = 0; k < 13; k++) s2.push_back(8'(8'h10 + k));
    exp_pl.delete();
    exp_len.delete();
    model_run({s1, s2}, drops);
    n0 = obs_pl.size();
    send_q(s1, 0);
    foreach (s2[k]) begin
      if (k == s2.size() - 1) chk("b2b_hold", payload, exp_pl[0]);
      send(s2[k], 0);
    end
    repeat (2) tick();
    chk("b2b_count", 512'(obs_pl.size()), 512'(n0 + 2));
    if (obs_pl.size() == n0 + 2) begin
      chk("b2b_pl0", obs_pl[n0], exp_pl[0]);
      chk("b2b_pl1", obs_pl[n0+1], exp_pl[1]);
      chk("b2b_len1", 512'(obs_len[n0+1]), 512'(13));
      chk("b2b_spacing", 512'(pcyc[n0+1] - pcyc[n0]), 512'(15));
    end
    chk("b2b_msgcnt", 512'(msg_count), 512'(7));
    send(8'h00, 0);
    send(8'h00, 0);
    chk("zero_pulse", 512'(drop_pulse), 512'(1));
    chk("zero_novalid", 512'(payload_valid), 512'(0));
    chk("zero_dropcnt", 512'(drop_count), 512'(1));
    tick();
    chk("zero_pulse_end", 512'(drop_pulse), 512'(0));
    send_q('{8'h00, 8'h03, 8'h41, 8'h42, 8'h43}, 0);
    tick();
    chk("after_zero_pl", payload, {24'h414243, 488'b0});
    chk("after_zero_len", 512'(payload_len), 512'(3));
    send(8'h00, 0);
    send(8'h41, 0);
    chk("over_pulse", 512'(drop_pulse), 512'(1));
    chk("over_dropcnt", 512'(drop_count), 512'(2));
    n0 = obs_pl.size();
    for (int k = 0; k < 65; k++) send(k % 3 == 0 ? 8'h00 : 8'h01, 0);
    send_q('{8'h00, 8'h01, 8'h58}, 0);
    tick();
    chk("over_valid", 512'(payload_valid), 512'(1));
    chk("over_pl", payload, {8'h58, 504'b0});
    chk("over_len", 512'(payload_len), 512'(1));
    chk("over_filler", 512'(obs_pl.size()), 512'(n0));
    chk("over_dropcnt2", 512'(drop_count), 512'(2));
    n0 = obs_pl.size() + 1;
    send_q('{8'h00, 8'h0D, 8'h41, 8'h01, 8'h02, 8'h03}, 0);
    in_flush = 1;
    send(8'h04, 0);
    in_flush = 0;
    send_q('{8'h00, 8'h02, 8'h44, 8'h45}, 0);
    tick();
    chk("flush_pl", payload, {16'h4445, 496'b0});
    chk("flush_nopulse", 512'(obs_pl.size()), 512'(n0));
    chk("flush_dropcnt", 512'(drop_count), 512'(2));
    repeat (6) begin
      send(8'h00, 0);
      send(8'h00, 0);
    end
    tick();
    chk("drop_saturate", 512'(drop_count), 512'(7));
    tot_msgs = 10;
    chk("msgcnt_10", 512'(msg_count), 512'(tot_msgs));
    for (int m = 0; m < 12; m++) begin
      int l;
      l = (m % 5 == 4) ? ($urandom_range(0, 1) ? 0 : int'($urandom_range(65, 72))) : int'($urandom_range(1, 64));
      sr.push_back(8'(l >> 8));
      sr.push_back(8'(l));
      repeat (l) sr.push_back(8'($urandom));
    end
    exp_pl.delete();
    exp_len.delete();
    model_run(sr, drops);
    n0 = obs_pl.size();
    send_q(sr, 3);
    repeat (4) tick();
    chk("rand_count", 512'(obs_pl.size()), 512'(n0 + exp_pl.size()));
    if (obs_pl.size() == n0 + exp_pl.size())
      foreach (exp_pl[i]) begin
        chk("rand_pl", obs_pl[n0+i], exp_pl[i]);
        chk("rand_len", 512'(obs_len[n0+i]), 512'(exp_len[i]));
      end
    tot_msgs += exp_pl.size();
    chk("rand_msgcnt_wrap", 512'(msg_count), 512'(tot_msgs % 16));
    chk("rand_dropcnt", 512'(drop_count), 512'(7));
    chk("no_overlap", 512'(overlap), 512'(0));
    send_q('{8'h00, 8'h0A, 8'h11, 8'h22, 8'h33}, 0);
    rst_n = 0;
    #1;
    chk("arst_valid", 512'(payload_valid), 512'(0));
    chk("arst_payload", payload, 512'(0));
    chk("arst_len", 512'(payload_len), 512'(0));
    chk("arst_msgcnt", 512'(msg_count), 512'(0));
    chk("arst_dropcnt", 512'(drop_count), 512'(0));
    @(negedge clk);
    rst_n = 1;
    tick();
    send_q('{8'h00, 8'h02, 8'h44, 8'h45}, 0);
    tick();
    chk("post_rst_valid", 512'(payload_valid), 512'(1));
    chk("post_rst_pl", payload, {16'h4445, 496'b0});
    chk("post_rst_msgcnt", 512'(msg_count), 512'(1));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
